// File: rtl/jesd204_soft_pcs_rx_comma_align_pkg.sv
// Shared soft-PCS receive definitions: K28.x comma patterns (abcdeif, a at LSB) and aligner states.
package jesd204_soft_pcs_rx_comma_align_pkg;

    localparam logic [6:0] COMMA_P = 7'b1111100;
    localparam logic [6:0] COMMA_N = 7'b0000011;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } align_state_t;

    function automatic logic is_comma(input logic [6:0] bits);
        return (bits == COMMA_P) || (bits == COMMA_N);
    endfunction

endpackage

// File: rtl/jesd204_soft_pcs_comma_detect.sv
// Combinational comma search over a two-cycle window; the lowest matching bit position wins.
// Zero latency, no flow control.
module jesd204_soft_pcs_comma_detect
    import jesd204_soft_pcs_rx_comma_align_pkg::*;
#(
    parameter int DATA_PATH_WIDTH = 4
) (
    input  logic [20*DATA_PATH_WIDTH-1:0] win,
    output logic                          found,
    output logic [3:0]                    found_offset
);

    localparam int W = 10 * DATA_PATH_WIDTH;

    // Descending scan so the lowest matching position is the last one written.
    always_comb begin
        found        = 1'b0;
        found_offset = 4'd0;
        for (int p = W - 1; p >= 0; p--) begin
            if (is_comma(win[p +: 7])) begin
                found        = 1'b1;
                found_offset = 4'(p % 10);
            end
        end
    end

endmodule

// File: rtl/jesd204_soft_pcs_rx_comma_align.sv
// Locks onto the 10b comma position in a raw bit stream and bit-shifts it onto character boundaries.
// One cycle from in_data to out_data; streaming, no backpressure.
module jesd204_soft_pcs_rx_comma_align
    import jesd204_soft_pcs_rx_comma_align_pkg::*;
#(
    parameter int DATA_PATH_WIDTH = 4,
    parameter int LOCK_COUNT      = 4,
    parameter int UNLOCK_COUNT    = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [10*DATA_PATH_WIDTH-1:0] in_data,
    input  logic                          align_enable,
    output logic [10*DATA_PATH_WIDTH-1:0] out_data,
    output logic                          out_aligned,
    output logic [3:0]                    out_offset,
    output logic                          out_comma
);

    localparam int         W           = 10 * DATA_PATH_WIDTH;
    localparam logic [2:0] LOCK_LAST   = 3'(LOCK_COUNT - 1);
    localparam logic [2:0] UNLOCK_LAST = 3'(UNLOCK_COUNT - 1);

    logic [W-1:0]   prev_q;
    logic [2*W-1:0] win;
    logic [W-1:0]   shifted;
    logic           found;
    logic [3:0]     found_offset;
    logic           at_offset;
    logic           off_offset;

    align_state_t   state_q, state_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [2:0]     miss_q, miss_d;
    logic [3:0]     offset_d;

    assign win     = {in_data, prev_q};
    assign shifted = W'(win >> out_offset);

    jesd204_soft_pcs_comma_detect #(
        .DATA_PATH_WIDTH (DATA_PATH_WIDTH)
    ) u_comma_detect (
        .win          (win),
        .found        (found),
        .found_offset (found_offset)
    );

    assign at_offset  = found && (found_offset == out_offset);
    assign off_offset = found && (found_offset != out_offset);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        miss_d   = miss_q;
        offset_d = out_offset;
        if (align_enable) begin
            unique case (state_q)
                ST_SEARCH: begin
                    if (found) begin
                        offset_d = found_offset;
                        cnt_d    = 3'd1;
                        miss_d   = 3'd0;
                        state_d  = (LOCK_COUNT == 1) ? ST_LOCKED : ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (at_offset) begin
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == LOCK_LAST) begin
                            state_d = ST_LOCKED;
                            miss_d  = 3'd0;
                        end
                    end else if (off_offset) begin
                        offset_d = found_offset;
                        cnt_d    = 3'd1;
                    end
                end
                ST_LOCKED: begin
                    // Silence is normal after CGS, so only a misplaced comma counts against lock.
                    if (off_offset) begin
                        miss_d = miss_q + 3'd1;
                        if (miss_q == UNLOCK_LAST) begin
                            state_d = ST_SEARCH;
                            cnt_d   = 3'd0;
                            miss_d  = 3'd0;
                        end
                    end else if (at_offset) begin
                        miss_d = 3'd0;
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q      <= '0;
            out_data    <= '0;
            out_aligned <= 1'b0;
            out_offset  <= 4'd0;
            out_comma   <= 1'b0;
            state_q     <= ST_SEARCH;
            cnt_q       <= 3'd0;
            miss_q      <= 3'd0;
        end else begin
            prev_q      <= in_data;
            out_data    <= shifted;
            out_comma   <= found;
            out_offset  <= offset_d;
            out_aligned <= (state_d == ST_LOCKED);
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            miss_q      <= miss_d;
        end
    end

endmodule

// File: tb/tb_jesd204_soft_pcs_rx_comma_align.sv
// Bench for the comma aligner: directed K28.5 stream scenarios plus randomized traffic,
// all checked every cycle against a bit-stream level reference model.
module tb_jesd204_soft_pcs_rx_comma_align;

    localparam int W      = 40;
    localparam int LOCK   = 4;
    localparam int UNLOCK = 3;
    localparam logic [W-1:0] K285_WORD = {10'h283, 10'h17C, 10'h283, 10'h17C};

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in_data;
    logic         align_enable;
    logic [W-1:0] out_data;
    logic         out_aligned;
    logic [3:0]   out_offset;
    logic         out_comma;

    always #5 clk = ~clk;

    jesd204_soft_pcs_rx_comma_align #(
        .DATA_PATH_WIDTH (4),
        .LOCK_COUNT      (LOCK),
        .UNLOCK_COUNT    (UNLOCK)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .align_enable (align_enable),
        .out_data     (out_data),
        .out_aligned  (out_aligned),
        .out_offset   (out_offset),
        .out_comma    (out_comma)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: offset plus run/miss tallies; "searching" is simply not locked with no run.
    logic [W-1:0] m_prev = '0;
    int           m_off = 0, m_hits = 0, m_miss = 0;
    bit           m_locked = 0;
    logic [W-1:0] nx_data, ex_data;
    logic [3:0]   nx_off, ex_off;
    bit           nx_aligned, ex_aligned, nx_comma, ex_comma;
    bit           chk_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input bit rst, input logic [W-1:0] d, input bit en);
        logic [2*W-1:0] w;
        bit found;
        int fo;
        w = {d, m_prev};
        found = 0;
        fo = 0;
        for (int p = 0; p < W; p++)
            if (!found && (w[p +: 7] == 7'b1111100 || w[p +: 7] == 7'b0000011)) begin
                found = 1;
                fo = p % 10;
            end
        if (rst) begin
            m_prev = '0; m_off = 0; m_hits = 0; m_miss = 0; m_locked = 0;
            nx_data = '0; nx_comma = 0;
        end else begin
            nx_data  = W'(w >> m_off);
            nx_comma = found;
            if (en && found) begin
                if (!m_locked) begin
                    if (m_hits > 0 && fo == m_off) m_hits++;
                    else begin m_off = fo; m_hits = 1; end
                    if (m_hits >= LOCK) begin m_locked = 1; m_miss = 0; end
                end else if (fo == m_off) begin
                    m_miss = 0;
                end else begin
                    m_miss++;
                    if (m_miss >= UNLOCK) begin m_locked = 0; m_hits = 0; m_miss = 0; end
                end
            end
            m_prev = d;
        end
        nx_off = 4'(m_off);
        nx_aligned = m_locked;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_data",    64'(out_data),    64'(ex_data));
            chk("out_offset",  64'(out_offset),  64'(ex_off));
            chk("out_aligned", 64'(out_aligned), 64'(ex_aligned));
            chk("out_comma",   64'(out_comma),   64'(ex_comma));
        end
    end

    task automatic step(input bit rst, input logic [W-1:0] d, input bit en);
        reset = rst;
        in_data = d;
        align_enable = en;
        model_step(rst, d, en);
        @(posedge clk);
        #1;
        ex_data = nx_data; ex_off = nx_off; ex_aligned = nx_aligned; ex_comma = nx_comma;
        chk_en = 1;
    endtask

    // Serial bit stream source: K28.5 with running disparity, or comma-free random characters.
    bit bq[$];
    bit rd, rand_mode, run_bit;
    int run_len;

    task automatic push_bits(input logic [9:0] c, input int n);
        for (int i = 0; i < n; i++) begin
            bq.push_back(c[i]);
            if (c[i] == run_bit) run_len++;
            else begin run_bit = c[i]; run_len = 1; end
        end
    endtask

    function automatic bit run_ok(input logic [9:0] c);
        int rl = run_len;
        bit rb = run_bit;
        for (int i = 0; i < 10; i++) begin
            if (c[i] == rb) rl++;
            else begin rb = c[i]; rl = 1; end
            if (rl >= 5) return 0;
        end
        return 1;
    endfunction

    task automatic push_char();
        logic [9:0] c;
        if (!rand_mode) begin
            c = rd ? 10'h283 : 10'h17C;
            rd = !rd;
        end else begin
            do c = 10'($urandom); while (!run_ok(c));
        end
        push_bits(c, 10);
    endtask

    task automatic stream_reset(input int k);
        bq.delete();
        rd = 0; rand_mode = 0; run_bit = 0; run_len = 0;
        push_bits(10'd0, k);
    endtask

    task automatic stream_step(input int extra, input bit en);
        logic [W-1:0] d;
        push_bits(10'd0, extra);
        while (bq.size() < W) push_char();
        for (int i = 0; i < W; i++) d[i] = bq.pop_front();
        step(0, d, en);
    endtask

    task automatic do_reset();
        step(1, '0, 1);
        step(1, '0, 1);
    endtask

    initial begin
        logic [W-1:0] pat, d;
        int ro;

        // Reset held with random data, then comma-free data.
        for (int i = 0; i < 5; i++) step(1, {8'($urandom), $urandom}, 1);
        chk("rst out_data",    64'(out_data),    64'd0);
        chk("rst out_offset",  64'(out_offset),  64'd0);
        chk("rst out_aligned", 64'(out_aligned), 64'd0);
        chk("rst out_comma",   64'(out_comma),   64'd0);
        for (int i = 0; i < 6; i++) begin
            step(0, 40'h55_5555_5555, 1);
            chk("nocomma aligned", 64'(out_aligned), 64'd0);
        end

        // K28.5 stream delayed 3 bits.
        do_reset();
        stream_reset(3);
        for (int s = 1; s <= 12; s++) begin
            stream_step(0, 1);
            if (s == 1) chk("t2 no comma yet", 64'(out_comma), 64'd0);
            if (s == 2) chk("t2 offset", 64'(out_offset), 64'd3);
            if (s == 4) chk("t2 not yet locked", 64'(out_aligned), 64'd0);
            if (s == 5) chk("t2 locked", 64'(out_aligned), 64'd1);
            if (s >= 3) chk("t2 k28.5 chars", 64'(out_data), 64'(K285_WORD));
        end

        // One-bit slip while checking restarts the count at offset 4.
        do_reset();
        stream_reset(3);
        for (int s = 1; s <= 10; s++) begin
            stream_step((s == 3) ? 1 : 0, 1);
            if (s == 4) chk("t3 offset moved", 64'(out_offset), 64'd4);
            if (s == 6) chk("t3 still checking", 64'(out_aligned), 64'd0);
            if (s == 7) chk("t3 relocked", 64'(out_aligned), 64'd1);
        end

        // Locked at 3: two misses then a correct comma keeps lock; a lasting slip unlocks.
        do_reset();
        stream_reset(3);
        for (int s = 0; s < 8; s++) stream_step(0, 1);
        for (int s = 0; s < 8; s++) begin
            stream_step((s == 0) ? 2 : (s == 2) ? 8 : 0, 1);
            chk("t4 lock held", 64'(out_aligned), 64'd1);
        end
        chk("t4 offset held", 64'(out_offset), 64'd3);
        for (int s = 0; s < 12; s++) begin
            stream_step((s == 0) ? 2 : 0, 1);
            if (s == 2) chk("t4 two misses", 64'(out_aligned), 64'd1);
            if (s == 3) chk("t4 unlocked", 64'(out_aligned), 64'd0);
        end
        chk("t4 relock offset", 64'(out_offset), 64'd5);
        chk("t4 relocked", 64'(out_aligned), 64'd1);

        // Frozen alignment while disabled, then unlock after enabling.
        for (int s = 0; s < 6; s++) begin
            stream_step((s == 0) ? 2 : 0, 0);
            chk("t5 frozen offset", 64'(out_offset), 64'd5);
            chk("t5 frozen lock", 64'(out_aligned), 64'd1);
        end
        for (int s = 0; s < 3; s++) begin
            stream_step(0, 1);
            chk("t5 unlock timing", 64'(out_aligned), (s == 2) ? 64'd0 : 64'd1);
        end

        // Randomized: rotated K28.5 words with occasional noise, enable drops and resets.
        pat = K285_WORD;
        ro = 0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) ro = $urandom_range(0, 9);
            if ($urandom_range(0, 99) < 10) d = {8'($urandom), $urandom};
            else d = (pat << ro) | (pat >> (W - ro));
            step($urandom_range(0, 99) < 2, d, $urandom_range(0, 99) < 85);
        end

        // Every bit delay: K28.5 preamble then comma-free random characters.
        for (int k = 0; k < 10; k++) begin
            do_reset();
            stream_reset(k);
            for (int s = 0; s < 6; s++) stream_step(0, 1);
            rand_mode = 1;
            for (int s = 0; s < 60; s++) stream_step(0, 1);
            chk("t6 lock kept", 64'(out_aligned), 64'd1);
            chk("t6 offset", 64'(out_offset), 64'(k));
        end

        @(negedge clk);
        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
